imem_loader: RTL and testbench

//  Byte-stream program loader: writer side of the instruction memory that the core's fetch path reads.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader that packs little-endian words into IMEM and holds the core until a good load.
// Optional IMEM_LOADER_TIMEOUT_EN: abort a stalled frame after TIMEOUT_CYC idle cycles.
module imem_loader #(
  parameter int addrW       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             sysCLK,
  input  logic             sysRST,
  input  logic [7:0]       inByte,
  input  logic             inValid,
  output logic             inReady,
  output logic [addrW-1:0] imemWAddr,
  output logic [31:0]      imemWData,
  output logic             imemWEn,
  output logic             cpuHold,
  output logic             loadDone,
  output logic             loadErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      widx_q, widx_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;
  logic [addrW-1:0] waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wen_q, wen_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             tmo_hit;
  logic [31:0]      word_nx;

  assign inReady   = (state_q != S_DONE);
  assign accept    = inValid & inReady;
  assign word_nx   = {inByte, word_q[31:8]};
  assign imemWAddr = waddr_q;
  assign imemWData = wdata_q;
  assign imemWEn   = wen_q;
  assign cpuHold   = hold_q;
  assign loadDone  = done_q;
  assign loadErr   = err_q;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM}) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysCLK) begin
    if (sysRST) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && inByte == 8'hA5) begin
          state_d = S_LEN0;
          hold_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = inByte;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = inByte;
          widx_d      = '0;
          bidx_d      = '0;
          csum_d      = '0;
          state_d     = ({inByte, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_nx;
          csum_d = csum_q ^ inByte;
          bidx_d = bidx_q + 2'd1;
          // last byte of a word: strobe it out next cycle while the stream continues
          if (bidx_q == 2'd3) begin
            wen_d   = 1'b1;
            wdata_d = word_nx;
            waddr_d = widx_q[addrW-1:0];
            widx_d  = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (inByte == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge sysCLK) begin
    if (sysRST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, gaps, zero length and mid-frame reset.
// Timeout scenario runs only when IMEM_LOADER_TIMEOUT_EN is defined.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        imem_wen;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int vec;
  int errs;
  int done_cnt;
  logic [15:0] wr_a[$];
  logic [31:0] wr_d[$];

  imem_loader #(.addrW(16), .TIMEOUT_CYC(20)) dut (
    .sysCLK    (clk),
    .sysRST    (rst),
    .inByte    (in_byte),
    .inValid   (in_valid),
    .inReady   (in_ready),
    .imemWAddr (imem_waddr),
    .imemWData (imem_wdata),
    .imemWEn   (imem_wen),
    .cpuHold   (cpu_hold),
    .loadDone  (load_done),
    .loadErr   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wen) begin
      wr_a.push_back(imem_waddr);
      wr_d.push_back(imem_wdata);
    end
    if (load_done) done_cnt = done_cnt + 1;
  end

  task clear_log();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
  endtask

  task send(input logic [7:0] b, input bit rnd_gap);
    int k;
    k = 0;
    if (rnd_gap) begin
      while ($urandom_range(1) == 1) @(posedge clk);
    end
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k >= 10) begin
      vec++;
      errs++;
      $display("FAIL send_ready: inReady=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task frame2(input logic [7:0] cs, input bit rnd_gap);
    logic [7:0] f[15];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 11; i++) send(f[i], rnd_gap);
    send(cs, rnd_gap);
  endtask

  task check_two_writes(input string tag);
    vec++;
    if (wr_a.size() !== 2) begin
      errs++;
      $display("FAIL %s_count: got %0d writes required 2", tag, wr_a.size());
    end else begin
      vec++;
      if (wr_a[0] !== 16'd0 || wr_d[0] !== 32'h00000013 ||
          wr_a[1] !== 16'd1 || wr_d[1] !== 32'h00100093) begin
        errs++;
        $display("FAIL %s_data: got (%h,%h)(%h,%h) required (0000,00000013)(0001,00100093)",
                 tag, wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
    end
  endtask

  task test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({in_ready, imem_wen, cpu_hold, load_done, load_err} !== 5'b10100) begin
      errs++;
      $display("FAIL reset_ctl: got rdy/wen/hold/done/err=%b required 10100",
               {in_ready, imem_wen, cpu_hold, load_done, load_err});
    end
    vec++;
    if (imem_waddr !== 16'd0 || imem_wdata !== 32'd0) begin
      errs++;
      $display("FAIL reset_bus: got addr=%h data=%h required 0/0", imem_waddr, imem_wdata);
    end
    rst = 1'b0;
  endtask

  task test_good_load();
    logic [7:0] f[12];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    clear_log();
    for (int i = 0; i < 12; i++) begin
      send(f[i], 1'b0);
      @(negedge clk);
      if (i == 0) begin
        vec++;
        if (cpu_hold !== 1'b1) begin
          errs++;
          $display("FAIL good_hold_sync: got %b required 1", cpu_hold);
        end
      end
      if (i == 6) begin
        vec++;
        if (imem_wen !== 1'b1 || imem_wdata !== 32'h00000013) begin
          errs++;
          $display("FAIL good_wen_lat: got wen=%b data=%h required 1/00000013", imem_wen, imem_wdata);
        end
      end
      if (i == 11) begin
        vec++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
          errs++;
          $display("FAIL good_done_lat: got done=%b hold=%b rdy=%b required 1/0/0",
                   load_done, cpu_hold, in_ready);
        end
      end
    end
    repeat (3) @(posedge clk);
    check_two_writes("good");
    vec++;
    if (done_cnt !== 1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      errs++;
      $display("FAIL good_final: got done_cnt=%0d err=%b hold=%b required 1/0/0",
               done_cnt, load_err, cpu_hold);
    end
  endtask

  task test_bad_csum();
    clear_log();
    frame2(8'h91, 1'b0);
    repeat (3) @(posedge clk);
    check_two_writes("badcs");
    vec++;
    if (done_cnt !== 0 || load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errs++;
      $display("FAIL badcs_flags: got done_cnt=%0d err=%b hold=%b required 0/1/1",
               done_cnt, load_err, cpu_hold);
    end
  endtask

  task test_garbage();
    logic [7:0] f[11];
    f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    clear_log();
    for (int i = 0; i < 11; i++) begin
      send(f[i], 1'b0);
      if (i == 2) begin
        @(negedge clk);
        vec++;
        if (load_err !== 1'b1) begin
          errs++;
          $display("FAIL garb_err_held: got %b required 1", load_err);
        end
      end
      if (i == 3) begin
        @(negedge clk);
        vec++;
        if (load_err !== 1'b0) begin
          errs++;
          $display("FAIL garb_err_clr: got %b required 0", load_err);
        end
      end
    end
    repeat (3) @(posedge clk);
    vec++;
    if (wr_a.size() !== 1) begin
      errs++;
      $display("FAIL garb_count: got %0d writes required 1", wr_a.size());
    end else begin
      vec++;
      if (wr_a[0] !== 16'd0 || wr_d[0] !== 32'hDEADBEEF) begin
        errs++;
        $display("FAIL garb_data: got (%h,%h) required (0000,deadbeef)", wr_a[0], wr_d[0]);
      end
    end
    vec++;
    if (done_cnt !== 1 || cpu_hold !== 1'b0) begin
      errs++;
      $display("FAIL garb_done: got done_cnt=%0d hold=%b required 1/0", done_cnt, cpu_hold);
    end
  endtask

  task test_zero_len();
    clear_log();
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    repeat (3) @(posedge clk);
    vec++;
    if (wr_a.size() !== 0 || done_cnt !== 1 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL zero_good: got writes=%0d done_cnt=%0d err=%b required 0/1/0",
               wr_a.size(), done_cnt, load_err);
    end
    clear_log();
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    repeat (3) @(posedge clk);
    vec++;
    if (wr_a.size() !== 0 || done_cnt !== 0 || load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errs++;
      $display("FAIL zero_bad: got writes=%0d done_cnt=%0d err=%b hold=%b required 0/0/1/1",
               wr_a.size(), done_cnt, load_err, cpu_hold);
    end
  endtask

  task test_random_valid();
    clear_log();
    frame2(8'h90, 1'b1);
    repeat (3) @(posedge clk);
    check_two_writes("rndv");
    vec++;
    if (done_cnt !== 1 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL rndv_done: got done_cnt=%0d err=%b required 1/0", done_cnt, load_err);
    end
  endtask

  task test_reset_mid();
    logic [7:0] f[9];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    clear_log();
    for (int i = 0; i < 9; i++) send(f[i], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vec++;
    if (wr_a.size() !== 1 || done_cnt !== 0) begin
      errs++;
      $display("FAIL rstmid_writes: got writes=%0d done_cnt=%0d required 1/0", wr_a.size(), done_cnt);
    end
    vec++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b1 || load_err !== 1'b0 || imem_waddr !== 16'd0) begin
      errs++;
      $display("FAIL rstmid_state: got hold=%b rdy=%b err=%b addr=%h required 1/1/0/0000",
               cpu_hold, in_ready, load_err, imem_waddr);
    end
    // leftover payload bytes must be dropped by IDLE
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    clear_log();
    frame2(8'h90, 1'b0);
    repeat (3) @(posedge clk);
    check_two_writes("rstmid_reload");
    vec++;
    if (done_cnt !== 1 || cpu_hold !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_reload_done: got done_cnt=%0d hold=%b required 1/0", done_cnt, cpu_hold);
    end
  endtask

`ifdef IMEM_LOADER_TIMEOUT_EN
  task test_timeout();
    clear_log();
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    vec++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errs++;
      $display("FAIL tmo_fire: got err=%b hold=%b required 1/1", load_err, cpu_hold);
    end
    clear_log();
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    repeat (19) @(posedge clk);
    send(8'h13, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h93, 1'b0);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    send(8'h90, 1'b0);
    repeat (3) @(posedge clk);
    check_two_writes("tmo_edge");
    vec++;
    if (done_cnt !== 1 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL tmo_edge_done: got done_cnt=%0d err=%b required 1/0", done_cnt, load_err);
    end
  endtask
`endif

  initial begin
    vec = 0;
    errs = 0;
    done_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    test_reset();
    test_good_load();
    test_bad_csum();
    test_garbage();
    test_zero_len();
    test_random_valid();
    test_reset_mid();
`ifdef IMEM_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
